// File: rtl/vref_step_ctrl.sv
// vref_step_ctrl: turns single-cycle Vref step/reload requests from the
// trainer into a bounded DAC code. After each code change it holds a settle
// window. It also exposes a 3-register APB window at VREF_BASE_ADDR
// (reload value, current code, drop counter).
//
// Optional feature: define VREF_STEP_DROP_CNT_EN to build an 8-bit saturating
// counter of step requests dropped during settle. It reads at base+2 and is
// cleared by any write to base+2. Without the macro, base+2 reads 0 and
// writes to it are ignored.
module vref_step_ctrl #(
    parameter int unsigned CODE_W         = 7,
    parameter int unsigned CODE_MIN       = 0,
    parameter int unsigned CODE_MAX       = 127,
    parameter int unsigned CODE_DEFAULT   = 64,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter logic [15:0] VREF_BASE_ADDR = 16'h0050
) (
    input  logic              SCLK,
    input  logic              reset_n,
    input  logic              vref_move,
    input  logic              vref_direction,
    input  logic              vref_reload,
    output logic              vref_out_of_range,
    output logic [CODE_W-1:0] vref_code,
    output logic              vref_busy,
    output logic              vref_code_valid,
    input  logic [15:0]       apb_addr,
    input  logic              apb_we,
    input  logic [7:0]        apb_wrdata,
    output logic [7:0]        step_rddata
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CODE_W-1:0] C_MIN     = CODE_W'(CODE_MIN);
    localparam logic [CODE_W-1:0] C_MAX     = CODE_W'(CODE_MAX);
    localparam logic [CODE_W-1:0] C_DEFAULT = CODE_W'(CODE_DEFAULT);
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [15:0] ADDR_RELOAD = VREF_BASE_ADDR;
    localparam logic [15:0] ADDR_CODE   = VREF_BASE_ADDR + 16'd1;
    localparam logic [15:0] ADDR_DROP   = VREF_BASE_ADDR + 16'd2;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic [CODE_W-1:0] reload_val;
    logic [CODE_W-1:0] wr_code;
    logic [CODE_W-1:0] wr_clamped;
    logic              oor, oor_nxt;
    logic              oor_dir, oor_dir_nxt;   // direction of the last rejected move
    logic              at_limit;
    logic              reload_wr;
    logic [7:0]        drop_rd;
    logic              unused_wrdata;

    // Bits of the write data above CODE_W carry no meaning for the reload value.
    assign unused_wrdata = ^apb_wrdata;

    assign wr_code   = apb_wrdata[CODE_W-1:0];
    assign reload_wr = apb_we && (apb_addr == ADDR_RELOAD);

    // A step that would leave the legal range is rejected before the
    // arithmetic, so the code can never wrap.
    assign at_limit = ( vref_direction && (vref_code == C_MAX)) ||
                      (!vref_direction && (vref_code == C_MIN));

    // Clamp an APB-written reload value into the legal code range.
    always_comb begin
        if (wr_code <= C_MIN) begin
            wr_clamped = C_MIN;
        end else if (wr_code >= C_MAX) begin
            wr_clamped = C_MAX;
        end else begin
            wr_clamped = wr_code;
        end
    end

    // Next-state logic: request arbitration, range check and settle countdown.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt   = state;
        cnt_nxt     = cnt;
        code_nxt    = vref_code;
        oor_nxt     = oor;
        oor_dir_nxt = oor_dir;
        case (state)
            IDLE: begin
                if (vref_reload) begin
                    code_nxt  = reload_val;
                    oor_nxt   = 1'b0;
                    cnt_nxt   = SETTLE_LD;
                    state_nxt = SETTLE;
                end else if (vref_move) begin
                    if (at_limit) begin
                        oor_nxt     = 1'b1;
                        oor_dir_nxt = vref_direction;
                    end else begin
                        code_nxt  = vref_direction ? (vref_code + CODE_W'(1))
                                                   : (vref_code - CODE_W'(1));
                        cnt_nxt   = SETTLE_LD;
                        state_nxt = SETTLE;
                        // Only a move away from the limit that was hit clears the flag.
                        if (oor && (oor_dir != vref_direction)) begin
                            oor_nxt = 1'b0;
                        end
                    end
                end
            end
            SETTLE: begin
                if (vref_reload) begin
                    code_nxt = reload_val;
                    oor_nxt  = 1'b0;
                    cnt_nxt  = SETTLE_LD;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state and code registers.
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            vref_code <= C_DEFAULT;
            oor       <= 1'b0;
            oor_dir   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            vref_code <= code_nxt;
            oor       <= oor_nxt;
            oor_dir   <= oor_dir_nxt;
        end
    end

    // Reload value register. A reload in the same cycle still sees the old value.
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            reload_val <= C_DEFAULT;
        end else if (reload_wr) begin
            reload_val <= wr_clamped;
        end
    end

`ifdef VREF_STEP_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Count step requests dropped during settle. Saturate at 255; clear on write to base+2.
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= 8'h00;
        end else if (apb_we && (apb_addr == ADDR_DROP)) begin
            drop_cnt <= 8'h00;
        end else if (vref_move && (state == SETTLE) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign drop_rd = drop_cnt;
`else
    assign drop_rd = 8'h00;
`endif

    // Combinational APB read mux, zero-extended to the 8-bit bus.
    always_comb begin
        step_rddata = 8'h00;
        if (apb_addr == ADDR_RELOAD) begin
            step_rddata = 8'(reload_val);
        end else if (apb_addr == ADDR_CODE) begin
            step_rddata = 8'(vref_code);
        end else if (apb_addr == ADDR_DROP) begin
            step_rddata = drop_rd;
        end
    end

    assign vref_out_of_range = oor;
    assign vref_busy         = (state == SETTLE);
    assign vref_code_valid   = !vref_busy;

endmodule

// File: tb/tb_vref_step_ctrl.sv
// Testbench for vref_step_ctrl. The stimulus pushes expected values into a
// queue. Two monitors check them: one compares queued values when a sample
// is requested, and one measures every busy window as it closes.
module tb_vref_step_ctrl;

    localparam logic [15:0] BASE = 16'h0050;

    logic       SCLK;
    logic       reset_n;
    logic       vref_move;
    logic       vref_direction;
    logic       vref_reload;
    logic       vref_out_of_range;
    logic [6:0] vref_code;
    logic       vref_busy;
    logic       vref_code_valid;
    logic [15:0] apb_addr;
    logic       apb_we;
    logic [7:0] apb_wrdata;
    logic [7:0] step_rddata;

    vref_step_ctrl dut (
        .SCLK              (SCLK),
        .reset_n           (reset_n),
        .vref_move         (vref_move),
        .vref_direction    (vref_direction),
        .vref_reload       (vref_reload),
        .vref_out_of_range (vref_out_of_range),
        .vref_code         (vref_code),
        .vref_busy         (vref_busy),
        .vref_code_valid   (vref_code_valid),
        .apb_addr          (apb_addr),
        .apb_we            (apb_we),
        .apb_wrdata        (apb_wrdata),
        .step_rddata       (step_rddata)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    typedef enum {K_CODE, K_BUSY, K_VALID, K_OOR, K_RD} kind_t;
    typedef struct {
        kind_t kind;
        string name;
        int    exp;
    } exp_t;

    exp_t exp_q[$];
    int   len_q[$];
    int   n_cmp;
    int   n_fail;
    event chk_ev;

`ifdef VREF_STEP_DROP_CNT_EN
    localparam int DROP_AFTER_ONE = 1;
`else
    localparam int DROP_AFTER_ONE = 0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Monitor 1: drains queued expectations whenever a sample is requested.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_CODE:  check(e.name, int'(vref_code), e.exp);
                    K_BUSY:  check(e.name, int'(vref_busy), e.exp);
                    K_VALID: check(e.name, int'(vref_code_valid), e.exp);
                    K_OOR:   check(e.name, int'(vref_out_of_range), e.exp);
                    default: check(e.name, int'(step_rddata), e.exp);
                endcase
            end
        end
    end

    // Monitor 2: measures each busy window when it closes.
    initial begin
        int run;
        bit prev;
        int exp_len;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge SCLK);
            if (!reset_n) begin
                run  = 0;
                prev = 1'b0;
            end else if (vref_busy) begin
                run++;
                prev = 1'b1;
            end else begin
                if (prev) begin
                    if (len_q.size() == 0) begin
                        check("busy_len_unexpected", run, 0);
                    end else begin
                        exp_len = len_q.pop_front();
                        check("busy_len", run, exp_len);
                    end
                end
                run  = 0;
                prev = 1'b0;
            end
        end
    end

    task automatic expect_val(input kind_t k, input string name, input int v);
        exp_t e;
        e.kind = k;
        e.name = name;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge SCLK);
        #1;
    endtask

    task automatic check_now();
        @(negedge SCLK);
        -> chk_ev;
        #1;
    endtask

    task automatic check_async();
        -> chk_ev;
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && vref_busy; i++) step();
        if (vref_busy) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [7:0] d);
        apb_addr   = a;
        apb_wrdata = d;
        apb_we     = 1'b1;
        step();
        apb_we     = 1'b0;
    endtask

    task automatic expect_rd(input logic [15:0] a, input string name, input int v);
        apb_addr = a;
        expect_val(K_RD, name, v);
        check_now();
    endtask

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        vref_move      = 1'b0;
        vref_direction = 1'b0;
        vref_reload    = 1'b0;
        apb_addr       = BASE;
        apb_we         = 1'b0;
        apb_wrdata     = 8'h00;
        step(3);
        reset_n = 1'b1;

        // Reset state
        expect_val(K_CODE,  "rst_code", 64);
        expect_val(K_BUSY,  "rst_busy", 0);
        expect_val(K_VALID, "rst_valid", 1);
        expect_val(K_OOR,   "rst_oor", 0);
        expect_rd(BASE,          "rst_rd_reload", 8'h40);
        expect_rd(BASE + 16'd1,  "rst_rd_code", 8'h40);
        expect_rd(BASE + 16'd2,  "rst_rd_drop", 0);
        expect_rd(BASE + 16'd3,  "rd_unmapped", 0);

        // Move up, then a move dropped during settle
        vref_direction = 1'b1;
        vref_move      = 1'b1;
        len_q.push_back(16);
        expect_val(K_CODE,  "up_code", 65);
        expect_val(K_BUSY,  "up_busy", 1);
        expect_val(K_VALID, "up_valid", 0);
        check_now();
        vref_move = 1'b0;
        step();
        vref_move = 1'b1;
        expect_val(K_CODE, "drop_code", 65);
        check_now();
        vref_move = 1'b0;
        wait_idle(40);
        expect_val(K_CODE, "settled_code", 65);
        expect_rd(BASE + 16'd2, "drop_cnt_one", DROP_AFTER_ONE);
        apb_write(BASE + 16'd2, 8'h99);
        expect_rd(BASE + 16'd2, "drop_cnt_clr", 0);
        expect_rd(BASE, "reload_kept", 8'h40);

        // Upper limit: reject at 127, then a move down clears the flag
        apb_write(BASE, 8'h7F);
        expect_rd(BASE, "rd_reload_7f", 8'h7F);
        vref_reload = 1'b1;
        len_q.push_back(16);
        expect_val(K_CODE, "reload_127", 127);
        check_now();
        vref_reload = 1'b0;
        wait_idle(40);
        vref_direction = 1'b1;
        vref_move      = 1'b1;
        expect_val(K_CODE, "rej_up_code", 127);
        expect_val(K_OOR,  "rej_up_oor", 1);
        expect_val(K_BUSY, "rej_up_busy", 0);
        check_now();
        vref_direction = 1'b0;
        expect_val(K_CODE, "down_code", 126);
        expect_val(K_OOR,  "down_oor_clr", 0);
        len_q.push_back(16);
        check_now();
        vref_move = 1'b0;
        wait_idle(40);

        // Same-cycle write and reload uses the old reload value
        apb_addr    = BASE;
        apb_wrdata  = 8'h05;
        apb_we      = 1'b1;
        vref_reload = 1'b1;
        len_q.push_back(16);
        expect_val(K_CODE, "wr_reload_same_cycle", 127);
        check_now();
        apb_we      = 1'b0;
        vref_reload = 1'b0;
        expect_rd(BASE, "rd_reload_05", 5);
        wait_idle(40);

        // Reload to 5, re-issued 5 cycles into settle: one 21-cycle busy run
        vref_reload = 1'b1;
        len_q.push_back(21);
        expect_val(K_CODE, "reload_5", 5);
        check_now();
        vref_reload = 1'b0;
        step(4);
        vref_reload = 1'b1;
        expect_val(K_CODE, "rereload_code", 5);
        expect_val(K_BUSY, "rereload_busy", 1);
        check_now();
        vref_reload = 1'b0;
        wait_idle(60);

        // Lower limit: reject at 0 twice (sticky), reload clears the flag
        apb_write(BASE, 8'h00);
        vref_reload = 1'b1;
        len_q.push_back(16);
        expect_val(K_CODE, "reload_0", 0);
        check_now();
        vref_reload = 1'b0;
        wait_idle(40);
        vref_direction = 1'b0;
        vref_move      = 1'b1;
        expect_val(K_CODE, "rej_dn_code", 0);
        expect_val(K_OOR,  "rej_dn_oor", 1);
        check_now();
        vref_move = 1'b0;
        step();
        vref_move = 1'b1;
        expect_val(K_OOR,  "rej_dn_sticky", 1);
        expect_val(K_BUSY, "rej_dn_busy", 0);
        check_now();
        vref_move   = 1'b0;
        vref_reload = 1'b1;
        len_q.push_back(16);
        expect_val(K_OOR,  "reload_clr_oor", 0);
        expect_val(K_BUSY, "reload_busy", 1);
        check_now();
        vref_reload = 1'b0;
        wait_idle(40);

        // Reload and move together: reload wins, no step applied
        apb_write(BASE, 8'h20);
        vref_reload    = 1'b1;
        vref_move      = 1'b1;
        vref_direction = 1'b1;
        len_q.push_back(16);
        expect_val(K_CODE, "reload_beats_move", 8'h20);
        check_now();
        vref_reload = 1'b0;
        vref_move   = 1'b0;
        wait_idle(40);

        // Write data above CODE_W bits is discarded
        apb_write(BASE, 8'hFF);
        expect_rd(BASE, "wr_ff", 8'h7F);
        apb_write(BASE, 8'h85);
        expect_rd(BASE, "wr_85", 8'h05);

        // Asynchronous reset in the middle of settle
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step();
        vref_direction = 1'b1;
        vref_move      = 1'b1;
        expect_val(K_CODE, "pre_rst_code", 65);
        check_now();
        vref_move = 1'b0;
        step(7);
        apb_addr = BASE;
        reset_n  = 1'b0;
        #1;
        expect_val(K_CODE,  "async_rst_code", 64);
        expect_val(K_BUSY,  "async_rst_busy", 0);
        expect_val(K_VALID, "async_rst_valid", 1);
        expect_val(K_OOR,   "async_rst_oor", 0);
        expect_val(K_RD,    "async_rst_reload", 8'h40);
        check_async();
        step(2);
        reset_n = 1'b1;
        step();
        vref_move = 1'b1;
        len_q.push_back(16);
        expect_val(K_CODE, "post_rst_up", 65);
        check_now();
        vref_move = 1'b0;
        wait_idle(40);

        step(2);
        check("busy_len_pending", len_q.size(), 0);
        check("exp_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
